// File: rtl/aqp_ebus_arbiter.sv
// aqp_ebus_arbiter: borrows the Z80 ebus via BUSREQ/BUSACK and grants it round-robin to two FPGA masters
//   clk, reset_n                    system clock, asynchronous active-low reset
//   ebus_phi                        Z80 phase clock; every handshake step happens on its falling edge
//   ebus_busreq_n, ebus_busack_n    bus request to / raw acknowledge from the Z80
//   m0_*, m1_*                      requester 0 (ESP SPI) and 1 (DMA): request, grant, address, data, strobes
//   ebus_a .. ebus_iorq_n           registered copy of the granted requester's cycle, idle values otherwise
//   ebus_owned                      Z80 has acknowledged and a requester holds or is handing over the bus
module aqp_ebus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ebus_phi,
  output logic        ebus_busreq_n,
  input  logic        ebus_busack_n,
  input  logic        m0_busreq,
  input  logic        m1_busreq,
  output logic        m0_grant,
  output logic        m1_grant,
  input  logic [15:0] m0_a,
  input  logic [7:0]  m0_wrdata,
  input  logic        m0_wrdata_en,
  input  logic        m0_rd_n,
  input  logic        m0_wr_n,
  input  logic        m0_mreq_n,
  input  logic        m0_iorq_n,
  input  logic [15:0] m1_a,
  input  logic [7:0]  m1_wrdata,
  input  logic        m1_wrdata_en,
  input  logic        m1_rd_n,
  input  logic        m1_wr_n,
  input  logic        m1_mreq_n,
  input  logic        m1_iorq_n,
  output logic [15:0] ebus_a,
  output logic [7:0]  ebus_wrdata,
  output logic        ebus_wrdata_en,
  output logic        ebus_rd_n,
  output logic        ebus_wr_n,
  output logic        ebus_mreq_n,
  output logic        ebus_iorq_n,
  output logic        ebus_owned
);
  typedef enum logic [2:0] {IDLE, REQ, GRANT, GAP, WAIT_REL} state_t;
  state_t state;
  logic q_phi, ack_meta, s_ack_n, q_last;
  logic phi_falling, any_req, sel, hold_req;
  assign phi_falling = q_phi & ~ebus_phi;
  assign any_req = m0_busreq | m1_busreq;
  // on a tie the requester not served last wins; otherwise the lone requester
  assign sel = (m0_busreq & m1_busreq) ? ~q_last : m1_busreq;
  assign hold_req = m1_grant ? m1_busreq : m0_busreq;
  assign ebus_owned = ~s_ack_n & (state == GRANT || state == GAP);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      q_phi <= 1'b0;
      ack_meta <= 1'b1;
      s_ack_n <= 1'b1;
      q_last <= 1'b1;
      ebus_busreq_n <= 1'b1;
      m0_grant <= 1'b0;
      m1_grant <= 1'b0;
      ebus_a <= '0;
      ebus_wrdata <= '0;
      ebus_wrdata_en <= 1'b0;
      ebus_rd_n <= 1'b1;
      ebus_wr_n <= 1'b1;
      ebus_mreq_n <= 1'b1;
      ebus_iorq_n <= 1'b1;
    end else begin
      q_phi <= ebus_phi;
      ack_meta <= ebus_busack_n;
      s_ack_n <= ack_meta;
      // mux follows the grant registers, so the bus trails the grant by one clk in both directions
      ebus_a <= m0_grant ? m0_a : m1_grant ? m1_a : '0;
      ebus_wrdata <= m0_grant ? m0_wrdata : m1_grant ? m1_wrdata : '0;
      ebus_wrdata_en <= m0_grant ? m0_wrdata_en : m1_grant & m1_wrdata_en;
      ebus_rd_n <= m0_grant ? m0_rd_n : m1_grant ? m1_rd_n : 1'b1;
      ebus_wr_n <= m0_grant ? m0_wr_n : m1_grant ? m1_wr_n : 1'b1;
      ebus_mreq_n <= m0_grant ? m0_mreq_n : m1_grant ? m1_mreq_n : 1'b1;
      ebus_iorq_n <= m0_grant ? m0_iorq_n : m1_grant ? m1_iorq_n : 1'b1;
      case (state)
        IDLE: if (phi_falling && any_req) begin
          ebus_busreq_n <= 1'b0;
          state <= REQ;
        end
        REQ: if (phi_falling) begin
          if (!any_req) begin
            ebus_busreq_n <= 1'b1;
            state <= WAIT_REL;
          end else if (!s_ack_n) begin
            state <= GRANT;
            m0_grant <= ~sel;
            m1_grant <= sel;
            q_last <= sel;
          end
        end
        GRANT: if (phi_falling && !hold_req) begin
          state <= GAP;
          m0_grant <= 1'b0;
          m1_grant <= 1'b0;
        end
        GAP: if (phi_falling) begin
          if (any_req) begin
            state <= GRANT;
            m0_grant <= ~sel;
            m1_grant <= sel;
            q_last <= sel;
          end else begin
            ebus_busreq_n <= 1'b1;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: if (s_ack_n) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aqp_ebus_arbiter.sv
// tb_aqp_ebus_arbiter: directed, table-driven and randomized checks of the ebus arbiter
module tb_aqp_ebus_arbiter;
  logic clk = 0, reset_n = 0, ebus_phi = 0, ebus_busack_n = 1;
  logic ebus_busreq_n, m0_grant, m1_grant, ebus_owned;
  logic m0_busreq = 0, m1_busreq = 0;
  logic [15:0] m0_a = 0, m1_a = 0, ebus_a;
  logic [7:0] m0_wrdata = 0, m1_wrdata = 0, ebus_wrdata;
  logic m0_wrdata_en = 0, m1_wrdata_en = 0, ebus_wrdata_en;
  logic m0_rd_n = 1, m0_wr_n = 1, m0_mreq_n = 1, m0_iorq_n = 1;
  logic m1_rd_n = 1, m1_wr_n = 1, m1_mreq_n = 1, m1_iorq_n = 1;
  logic ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n;
  int checks = 0, errors = 0;
  localparam logic [32:0] RST = {1'b1, 3'b000, 16'h0, 8'h0, 1'b0, 4'hf};
  int phi_cnt = 2, zc = 0, ack_dly = 2, rel_dly = 2, gap;
  bit phi_rand = 0, z80_auto = 1, br_up, seen;
  bit m_busreq, m_gap, m_rel, phi_prev, h1, h2;
  int m_owner, m_last;
  logic [32:0] exp_out;
  typedef struct { logic r0; logic r1; logic [1:0] g; } rr_t;
  rr_t rr[6];

  aqp_ebus_arbiter dut (
    .clk(clk), .reset_n(reset_n), .ebus_phi(ebus_phi),
    .ebus_busreq_n(ebus_busreq_n), .ebus_busack_n(ebus_busack_n),
    .m0_busreq(m0_busreq), .m1_busreq(m1_busreq), .m0_grant(m0_grant), .m1_grant(m1_grant),
    .m0_a(m0_a), .m0_wrdata(m0_wrdata), .m0_wrdata_en(m0_wrdata_en),
    .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n), .m0_mreq_n(m0_mreq_n), .m0_iorq_n(m0_iorq_n),
    .m1_a(m1_a), .m1_wrdata(m1_wrdata), .m1_wrdata_en(m1_wrdata_en),
    .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n), .m1_mreq_n(m1_mreq_n), .m1_iorq_n(m1_iorq_n),
    .ebus_a(ebus_a), .ebus_wrdata(ebus_wrdata), .ebus_wrdata_en(ebus_wrdata_en),
    .ebus_rd_n(ebus_rd_n), .ebus_wr_n(ebus_wr_n), .ebus_mreq_n(ebus_mreq_n), .ebus_iorq_n(ebus_iorq_n),
    .ebus_owned(ebus_owned)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] outs();
    return {ebus_busreq_n, m0_grant, m1_grant, ebus_owned, ebus_a, ebus_wrdata, ebus_wrdata_en,
            ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n};
  endfunction

  function automatic logic [28:0] bus_of(int o);
    if (o == 0) return {m0_a, m0_wrdata, m0_wrdata_en, m0_rd_n, m0_wr_n, m0_mreq_n, m0_iorq_n};
    if (o == 1) return {m1_a, m1_wrdata, m1_wrdata_en, m1_rd_n, m1_wr_n, m1_mreq_n, m1_iorq_n};
    return {16'h0, 8'h0, 1'b0, 4'hf};
  endfunction

  task automatic chk(string name, logic [32:0] got, logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_busreq = 0; m_gap = 0; m_rel = 0; m_owner = -1; m_last = 1;
    phi_prev = 0; h1 = 1; h2 = 1; exp_out = RST;
  endtask

  // Reference: bus held/released, current owner, handover gap and release wait, advanced on each clk edge.
  task automatic model_edge();
    bit pf, s_old, any;
    int sel;
    logic [28:0] bus;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pf = phi_prev && !ebus_phi;
    s_old = h2;
    bus = bus_of(m_owner);
    any = m0_busreq || m1_busreq;
    sel = (m0_busreq && m1_busreq) ? 1 - m_last : (m1_busreq ? 1 : 0);
    if (m_rel) begin
      if (s_old) m_rel = 0;
    end else if (!m_busreq) begin
      if (pf && any) m_busreq = 1;
    end else if (m_owner >= 0) begin
      if (pf && !(m_owner == 1 ? m1_busreq : m0_busreq)) begin m_owner = -1; m_gap = 1; end
    end else if (pf && (m_gap || !s_old || !any)) begin
      if (any) begin m_owner = sel; m_last = sel; end
      else begin m_busreq = 0; m_rel = 1; end
      m_gap = 0;
    end
    phi_prev = ebus_phi;
    exp_out = {!m_busreq, m_owner == 0, m_owner == 1, !h1 && (m_owner >= 0 || m_gap), bus};
    h2 = h1;
    h1 = ebus_busack_n;
  endtask

  task automatic drive_env();
    if (phi_cnt <= 1) begin
      ebus_phi = !ebus_phi;
      phi_cnt = phi_rand ? int'($urandom_range(3, 1)) : 2;
    end else phi_cnt--;
    if (z80_auto && !ebus_busreq_n && ebus_busack_n) begin
      if (zc >= ack_dly) begin ebus_busack_n = 0; zc = 0; end else zc++;
    end else if (ebus_busreq_n && !ebus_busack_n) begin
      if (zc >= rel_dly) begin
        ebus_busack_n = 1; zc = 0;
        if (phi_rand) begin ack_dly = $urandom_range(8, 0); rel_dly = $urandom_range(6, 0); end
      end else zc++;
    end else zc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", outs(), exp_out);
    drive_env();
  endtask

  task automatic release_all();
    m0_busreq = 0; m1_busreq = 0;
    for (int i = 0; i < 40 && !ebus_busreq_n; i++) step();
    for (int i = 0; i < 40 && !ebus_busack_n; i++) step();
    repeat (4) step();
  endtask

  initial begin
    model_reset();
    rr[0] = '{1'b1, 1'b1, 2'b10};
    rr[1] = '{1'b1, 1'b1, 2'b01};
    rr[2] = '{1'b1, 1'b0, 2'b10};
    rr[3] = '{1'b1, 1'b1, 2'b01};
    rr[4] = '{1'b0, 1'b1, 2'b01};
    rr[5] = '{1'b1, 1'b1, 2'b10};
    repeat (3) step();
    chk("reset_outs", outs(), RST);
    reset_n = 1;
    repeat (2) step();
    // single request, slow Z80 acknowledge
    ack_dly = 12;
    m0_a = 16'h3800; m0_mreq_n = 0; m0_rd_n = 0;
    m0_busreq = 1;
    for (int i = 0; i < 40 && ebus_busreq_n; i++) step();
    chk("t1_busreq", 33'(ebus_busreq_n), 0);
    chk("t1_no_early_grant", 33'(m0_grant), 0);
    for (int i = 0; i < 100 && !m0_grant; i++) step();
    chk("t1_grant", 33'({m0_grant, m1_grant}), 'h2);
    step();
    chk("t1_addr", 33'(ebus_a), 'h3800);
    chk("t1_owned", 33'(ebus_owned), 1);
    m0_a = 16'h1234;
    step();
    chk("t1_addr_follow", 33'(ebus_a), 'h1234);
    chk("t1_strobes", 33'({ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n}), 'h5);
    // release
    ack_dly = 2;
    m0_busreq = 0;
    for (int i = 0; i < 20 && m0_grant; i++) step();
    chk("rel_grant_drop", 33'(m0_grant), 0);
    step();
    chk("rel_strobes_idle", 33'({ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n}), 'hf);
    chk("rel_gap_busreq", 33'(ebus_busreq_n), 0);
    for (int i = 0; i < 20 && !ebus_busreq_n; i++) step();
    chk("rel_busreq", 33'(ebus_busreq_n), 1);
    chk("rel_owned", 33'(ebus_owned), 0);
    m0_rd_n = 1; m0_mreq_n = 1;
    release_all();
    // tie from reset, handover through the gap
    reset_n = 0; step(); reset_n = 1; step();
    m0_busreq = 1; m1_busreq = 1;
    for (int i = 0; i < 60 && !(m0_grant || m1_grant); i++) step();
    chk("tie_first", 33'({m0_grant, m1_grant}), 'h2);
    m0_busreq = 0; gap = 0; br_up = 0;
    for (int i = 0; i < 40 && !m1_grant; i++) begin
      step();
      if (!m0_grant && !m1_grant) gap++;
      if (ebus_busreq_n) br_up = 1;
    end
    chk("tie_handover", 33'({m0_grant, m1_grant}), 'h1);
    chk("tie_gap_len", 33'(gap), 4);
    chk("tie_busreq_held", 33'(br_up), 0);
    release_all();
    // round-robin table
    for (int k = 0; k < 6; k++) begin
      m0_busreq = rr[k].r0; m1_busreq = rr[k].r1;
      for (int i = 0; i < 60 && !(m0_grant || m1_grant); i++) step();
      chk($sformatf("rr%0d", k), 33'({m0_grant, m1_grant}), 33'(rr[k].g));
      release_all();
    end
    // request withdrawn while waiting for BUSACK
    z80_auto = 0;
    m1_busreq = 1;
    for (int i = 0; i < 40 && ebus_busreq_n; i++) step();
    chk("wd_busreq", 33'(ebus_busreq_n), 0);
    m1_busreq = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m0_grant || m1_grant) seen = 1;
    end
    chk("wd_no_grant", 33'(seen), 0);
    chk("wd_busreq_rel", 33'(ebus_busreq_n), 1);
    z80_auto = 1;
    m0_busreq = 1;
    for (int i = 0; i < 10 && ebus_busreq_n; i++) step();
    chk("wd_rerequest", 33'(ebus_busreq_n), 0);
    for (int i = 0; i < 60 && !m0_grant; i++) step();
    release_all();
    // asynchronous reset during GRANT(1)
    m1_a = 16'hbeef; m1_rd_n = 0; m1_mreq_n = 0; m1_busreq = 1;
    for (int i = 0; i < 60 && !m1_grant; i++) step();
    step();
    chk("ar_pre", 33'({ebus_rd_n, ebus_mreq_n, m1_grant}), 'h1);
    #2 reset_n = 0;
    #1 chk("ar_outs", outs(), RST);
    step();
    reset_n = 1;
    for (int i = 0; i < 60 && !m1_grant; i++) step();
    chk("ar_regrant", 33'(m1_grant), 1);
    m1_rd_n = 1; m1_mreq_n = 1;
    release_all();
    // randomized traffic against the reference
    phi_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(m0_busreq ? 15 : 9, 0) == 0) m0_busreq = ~m0_busreq;
      if ($urandom_range(m1_busreq ? 15 : 9, 0) == 0) m1_busreq = ~m1_busreq;
      m0_a = 16'($urandom); m1_a = 16'($urandom);
      m0_wrdata = 8'($urandom); m1_wrdata = 8'($urandom);
      m0_wrdata_en = 1'($urandom); m1_wrdata_en = 1'($urandom);
      {m0_rd_n, m0_wr_n, m0_mreq_n, m0_iorq_n} = 4'($urandom);
      {m1_rd_n, m1_wr_n, m1_mreq_n, m1_iorq_n} = 4'($urandom);
      step();
    end
    release_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
